// File: rtl/data_io_pkg.sv
// ============================================================================
// Module : data_io_pkg
// Brief  : Command codes and widths shared by the data_io_loader block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_io_pkg;

  localparam int ADDR_W  = 25;
  localparam int INDEX_W = 8;

  typedef enum logic [7:0] {
    CMD_FILE_TX     = 8'h53,
    CMD_FILE_TX_DAT = 8'h54,
    CMD_FILE_INDEX  = 8'h55
  } cmd_e;

endpackage

`default_nettype wire

// File: rtl/spi_byte_rx.sv
// ============================================================================
// Module : spi_byte_rx
// Brief  : Mode-0 SPI slave receiver; synchronizes SCK/SS/DI into clk_i and
//          emits one-cycle byte strobes flagged as first-in-frame or payload.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_byte_rx (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       ss_n_i,
  input  logic       di_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       first_o
);

  logic [1:0] sck_sync_q;
  logic [1:0] ss_sync_q;
  logic [1:0] di_sync_q;
  logic       sck_prev_q;
  logic [2:0] cnt_q;
  logic [6:0] shift_q;
  logic       armed_q;
  logic       first_pend_q;
  logic       valid_q;
  logic [7:0] byte_q;
  logic       first_q;
  logic       w_sck_rise;

  assign w_sck_rise   = sck_sync_q[1] & ~sck_prev_q;
  assign byte_valid_o = valid_q;
  assign byte_o       = byte_q;
  assign first_o      = first_q;

  // Bytes are only accepted once SS has been seen high, so a frame that was
  // already in flight when reset released is never decoded from mid-stream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q   <= '0;
      ss_sync_q    <= '0;
      di_sync_q    <= '0;
      sck_prev_q   <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b0;
      first_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      byte_q       <= '0;
      first_q      <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], sck_i};
      ss_sync_q  <= {ss_sync_q[0], ss_n_i};
      di_sync_q  <= {di_sync_q[0], di_i};
      sck_prev_q <= sck_sync_q[1];
      valid_q    <= 1'b0;
      if (ss_sync_q[1]) begin
        cnt_q        <= '0;
        armed_q      <= 1'b1;
        first_pend_q <= 1'b1;
      end else if (w_sck_rise && armed_q) begin
        shift_q <= {shift_q[5:0], di_sync_q[1]};
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          valid_q      <= 1'b1;
          byte_q       <= {shift_q, di_sync_q[1]};
          first_q      <= first_pend_q;
          first_pend_q <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_io_loader.sv
// ============================================================================
// Module : data_io_loader
// Brief  : SPI-fed file loader producing a byte-wide write stream (ioctl_*).
//          Optional DATA_IO_CLKREF_EN gates writes on clkref_n low.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_io_loader
  import data_io_pkg::*;
(
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               SPI_SCK,
  input  logic               SPI_SS2,
  input  logic               SPI_DI,
  inout  wire                SPI_DO,
  input  logic               clkref_n,
  output logic               ioctl_wr,
  output logic [ADDR_W-1:0]  ioctl_addr,
  output logic [7:0]         ioctl_dout,
  output logic               ioctl_download,
  output logic [INDEX_W-1:0] ioctl_index
);

  logic               rx_valid;
  logic [7:0]         rx_byte;
  logic               rx_first;
  logic               w_ref_ok;

  logic [7:0]         cmd_q, cmd_d;
  logic               pay_first_q, pay_first_d;
  logic               pend_q, pend_d;
  logic [7:0]         pdata_q, pdata_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         dout_q, dout_d;
  logic               dl_q, dl_d;
  logic [INDEX_W-1:0] index_q, index_d;

  assign SPI_DO = 1'bz;

`ifdef DATA_IO_CLKREF_EN
  assign w_ref_ok = ~clkref_n;
`else
  logic unused_clkref;
  assign unused_clkref = clkref_n;
  assign w_ref_ok      = 1'b1;
`endif

  spi_byte_rx u_rx (
    .clk_i        (clk_sys),
    .rst_i        (reset),
    .sck_i        (SPI_SCK),
    .ss_n_i       (SPI_SS2),
    .di_i         (SPI_DI),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .first_o      (rx_first)
  );

  always_comb begin
    cmd_d       = cmd_q;
    pay_first_d = pay_first_q;
    pend_d      = pend_q;
    pdata_d     = pdata_q;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    dout_d      = dout_q;
    dl_d        = dl_q;
    index_d     = index_q;

    if (wr_q) addr_d = addr_q + 1'b1;

    // Issue precedes capture so a byte landing in the issue cycle stays pending.
    if (pend_q && w_ref_ok) begin
      wr_d   = 1'b1;
      dout_d = pdata_q;
      pend_d = 1'b0;
    end

    if (rx_valid) begin
      if (rx_first) begin
        cmd_d       = rx_byte;
        pay_first_d = 1'b1;
      end else begin
        pay_first_d = 1'b0;
        case (cmd_q)
          CMD_FILE_INDEX: if (pay_first_q) index_d = rx_byte;
          CMD_FILE_TX: begin
            if (pay_first_q) begin
              if (rx_byte != 8'h00) begin
                dl_d   = 1'b1;
                addr_d = '0;
              end else begin
                dl_d = 1'b0;
              end
            end
          end
          CMD_FILE_TX_DAT: begin
            if (dl_q) begin
              pend_d  = 1'b1;
              pdata_d = rx_byte;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cmd_q       <= '0;
      pay_first_q <= 1'b0;
      pend_q      <= 1'b0;
      pdata_q     <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      dl_q        <= 1'b0;
      index_q     <= '0;
    end else begin
      cmd_q       <= cmd_d;
      pay_first_q <= pay_first_d;
      pend_q      <= pend_d;
      pdata_q     <= pdata_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      dl_q        <= dl_d;
      index_q     <= index_d;
    end
  end

  assign ioctl_wr       = wr_q;
  assign ioctl_addr     = addr_q;
  assign ioctl_dout     = dout_q;
  assign ioctl_download = dl_q;
  assign ioctl_index    = index_q;

endmodule

`default_nettype wire

// File: tb/tb_data_io_loader.sv
// ============================================================================
// Module : tb_data_io_loader
// Brief  : Directed SPI frame bench for data_io_loader (DATA_IO_CLKREF_EN aware).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_io_loader;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        sck      = 1'b0;
  logic        ss       = 1'b1;
  logic        di       = 1'b0;
  logic        clkref_n = 1'b0;
  wire         spi_do;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;

  data_io_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .SPI_SCK        (sck),
    .SPI_SS2        (ss),
    .SPI_DI         (di),
    .SPI_DO         (spi_do),
    .clkref_n       (clkref_n),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;
  int wide  = 0;
  logic wr_prev = 1'b0;
  logic [24:0] cap_addr[$];
  logic [7:0]  cap_data[$];

  always @(negedge clk_sys) begin
    if (ioctl_wr) begin
      cap_addr.push_back(ioctl_addr);
      cap_data.push_back(ioctl_dout);
    end
    if (ioctl_wr && wr_prev) wide++;
    wr_prev = ioctl_wr;
  end

  typedef struct {
    logic [31:0] b;     // frame bytes, first byte in [31:24]
    int          nb;
    logic [7:0]  idx;
    logic        dl;
    logic [24:0] addr;
    int          nwr;
    logic [24:0] wa;
    logic [23:0] wd;    // expected write data, first write in [23:16]
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      di = v[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic ss_lo();
    ss = 1'b0;
    #40;
  endtask

  task automatic ss_hi();
    #40 ss = 1'b1;
    #400;
  endtask

  task automatic check_writes(input string name, input int nwr, input logic [24:0] wa,
                              input logic [23:0] wd);
    logic [23:0] d;
    d = wd;
    check({name, ".nwr"}, cap_addr.size(), nwr);
    for (int j = 0; j < nwr && j < cap_addr.size(); j++) begin
      check({name, ".waddr"}, cap_addr[j], wa + j);
      check({name, ".wdata"}, cap_data[j], d[23-8*j -: 8]);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h5501_0000, 2, 8'h01, 1'b0, 25'd0, 0, 25'd0, 24'h000000};
    vecs[1]  = '{32'h557E_3300, 3, 8'h7E, 1'b0, 25'd0, 0, 25'd0, 24'h000000};
    vecs[2]  = '{32'h53FF_0000, 2, 8'h7E, 1'b1, 25'd0, 0, 25'd0, 24'h000000};
    vecs[3]  = '{32'h54AA_BBCC, 4, 8'h7E, 1'b1, 25'd3, 3, 25'd0, 24'hAABBCC};
    vecs[4]  = '{32'h5300_0000, 2, 8'h7E, 1'b0, 25'd3, 0, 25'd0, 24'h000000};
    vecs[5]  = '{32'h5422_0000, 2, 8'h7E, 1'b0, 25'd3, 0, 25'd0, 24'h000000};
    vecs[6]  = '{32'h1254_9900, 3, 8'h7E, 1'b0, 25'd3, 0, 25'd0, 24'h000000};
    vecs[7]  = '{32'h53FF_0000, 2, 8'h7E, 1'b1, 25'd0, 0, 25'd0, 24'h000000};
    vecs[8]  = '{32'h5411_0000, 2, 8'h7E, 1'b1, 25'd1, 1, 25'd0, 24'h110000};
    vecs[9]  = '{32'h55A5_0000, 2, 8'hA5, 1'b1, 25'd1, 0, 25'd0, 24'h000000};
    vecs[10] = '{32'h545A_0000, 2, 8'hA5, 1'b1, 25'd2, 1, 25'd1, 24'h5A0000};

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst.wr",   ioctl_wr, 0);
    check("rst.addr", ioctl_addr, 0);
    check("rst.dout", ioctl_dout, 0);
    check("rst.dl",   ioctl_download, 0);
    check("rst.idx",  ioctl_index, 0);
    tests++;
    if (spi_do !== 1'bz) begin
      fails++;
      $display("FAIL rst.spi_do: got %b expected z", spi_do);
    end
    #2 reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    #2;

    for (int v = 0; v < 11; v++) begin
      logic [31:0] t;
      t = vecs[v].b;
      cap_addr.delete();
      cap_data.delete();
      ss_lo();
      for (int k = 0; k < vecs[v].nb; k++) spi_bits(t[31-8*k -: 8], 8);
      ss_hi();
      check($sformatf("v%0d.idx", v),  ioctl_index, vecs[v].idx);
      check($sformatf("v%0d.dl", v),   ioctl_download, vecs[v].dl);
      check($sformatf("v%0d.addr", v), ioctl_addr, vecs[v].addr);
      check_writes($sformatf("v%0d", v), vecs[v].nwr, vecs[v].wa, vecs[v].wd);
    end

    // Abort: partial byte at SS rise is dropped; address unchanged
    cap_addr.delete();
    cap_data.delete();
    ss_lo();
    spi_bits(8'h54, 8);
    spi_bits(8'hF0, 5);
    ss_hi();
    check("abort.nwr", cap_addr.size(), 0);
    check("abort.addr", ioctl_addr, 2);
    ss_lo();
    spi_bits(8'h54, 8);
    spi_bits(8'h3C, 8);
    ss_hi();
    check_writes("abort.next", 1, 25'd2, 24'h3C0000);
    check("abort.addr_after", ioctl_addr, 3);

    // clkref_n high while a data byte is pending
    ss_lo();
    spi_bits(8'h53, 8);
    spi_bits(8'hFF, 8);
    ss_hi();
    cap_addr.delete();
    cap_data.delete();
    clkref_n = 1'b1;
    ss_lo();
    spi_bits(8'h54, 8);
    spi_bits(8'h77, 8);
    ss_hi();
`ifdef DATA_IO_CLKREF_EN
    repeat (10) @(negedge clk_sys);
    check("clkref.held_nwr", cap_addr.size(), 0);
    clkref_n = 1'b0;
    repeat (5) @(negedge clk_sys);
    #2;
`else
    clkref_n = 1'b0;
`endif
    check_writes("clkref", 1, 25'd0, 24'h770000);
    check("clkref.addr_after", ioctl_addr, 1);

    // Reset pulsed during the third data byte
    cap_addr.delete();
    cap_data.delete();
    ss_lo();
    spi_bits(8'h54, 8);
    spi_bits(8'h01, 8);
    spi_bits(8'h02, 8);
    spi_bits(8'h03, 4);
    reset = 1'b1;
    @(negedge clk_sys);
    check("midrst.wr",   ioctl_wr, 0);
    check("midrst.addr", ioctl_addr, 0);
    check("midrst.dl",   ioctl_download, 0);
    check("midrst.idx",  ioctl_index, 0);
    check("midrst.dout", ioctl_dout, 0);
    #13 reset = 1'b0;
    spi_bits(8'h30, 4);
    ss_hi();
    check_writes("midrst", 2, 25'd1, 24'h010200);
    check("midrst.addr_after", ioctl_addr, 0);
    check("midrst.dl_after", ioctl_download, 0);

    check("wr_pulse_width", wide, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/data_io_loader.md
DATA_IO_LOADER -- requirements
Module: data_io_loader

Interface
REQ-001 SHALL have port clk_sys, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports SPI_SCK, SPI_SS2 and SPI_DI, each an input of 1 bit: the host SPI clock, the active-low select and MOSI data; all are asynchronous to clk_sys.
REQ-004 SHALL have port SPI_DO, inout, 1 bit: always high-Z, since the block never drives MISO.
REQ-005 SHALL have port clkref_n, input, 1 bit: active-low write-enable reference from the consumer.
REQ-006 SHALL have port ioctl_wr, output, 1 bit: one-clk_sys write strobe.
REQ-007 SHALL have port ioctl_addr, output, 25 bits: byte address of the current write.
REQ-008 SHALL have port ioctl_dout, output, 8 bits: write data.
REQ-009 SHALL have port ioctl_download, output, 1 bit: high while a download is active.
REQ-010 SHALL have port ioctl_index, output, 8 bits: file index selected by the host.

Function
REQ-011 SHALL pass SPI_SCK, SPI_SS2 and SPI_DI through 2-flop synchronizers to clk_sys; clk_sys SHALL be at least 4x the SCK frequency.
REQ-012 SHALL shift in DI MSB-first on each synchronized SCK rising edge while SS2 is low (SPI mode 0).
REQ-013 SHALL assemble a byte on every 8th bit.
REQ-014 SHALL reset the bit counter when SS2 is high; a partial byte at SS2 deassertion SHALL be discarded.
REQ-015 SHALL treat the first byte after SS2 falls as the command; subsequent bytes in the same frame are payload.
REQ-016 Command 0x55 (FILE_INDEX): the first payload byte SHALL be latched into ioctl_index; further payload bytes in the frame are ignored.
REQ-017 Command 0x53 (FILE_TX): a nonzero first payload byte SHALL set ioctl_download=1 and ioctl_addr=0.
REQ-018 Command 0x53 (FILE_TX): a zero first payload byte SHALL clear ioctl_download.
REQ-019 Command 0x54 (FILE_TX_DAT), while ioctl_download=1: every payload byte SHALL become a pending write.
REQ-020 Command 0x54 (FILE_TX_DAT), while ioctl_download=0: payload bytes SHALL be ignored.
REQ-021 For a pending write, ioctl_dout SHALL show the byte and ioctl_wr SHALL pulse high for exactly one clk_sys cycle at the current ioctl_addr.
REQ-022 ioctl_addr SHALL increment by 1 in the cycle after the ioctl_wr pulse.
REQ-023 ioctl_wr latency SHALL be at most 2 clk_sys cycles after the byte is assembled, provided clkref_n is low.
REQ-024 A new byte arriving while a write is still pending SHALL overwrite the pending data; the address advances once per issued write.
REQ-025 ioctl_addr SHALL wrap from 0x1FFFFFF to 0.
REQ-026 Unknown command bytes SHALL cause the rest of the frame to be ignored.
REQ-027 ioctl_index SHALL persist across downloads.

Reset
REQ-028 While reset is high, ioctl_wr, ioctl_download, ioctl_addr, ioctl_dout and ioctl_index SHALL all be 0, and the shifter, bit counter, command register and synchronizers SHALL be cleared.
REQ-029 When reset asserts mid-frame, the frame SHALL be aborted, any pending write dropped, and no ioctl_wr produced.

Configuration
REQ-030 When macro DATA_IO_CLKREF_EN is defined, a pending write SHALL wait until clkref_n is low, then issue in that cycle.
REQ-031 When DATA_IO_CLKREF_EN is undefined, clkref_n SHALL be ignored and writes issue immediately.

Structure
REQ-032 Package data_io_pkg SHALL hold the command constants (0x53, 0x54, 0x55), the address width (25) and the index width (8).
REQ-033 There SHALL be one sub-module, spi_byte_rx, containing the synchronizers, edge detect, shifter, bit counter and byte-valid/first-byte flags.

Verification
REQ-034 Reset: assert reset -> all outputs 0, SPI_DO is Z.
REQ-035 Index: frame 0x55,0x01 -> ioctl_index=0x01 and ioctl_download stays 0.
REQ-036 Download: frames 0x53,0xFF; then 0x54,0xAA,0xBB,0xCC; then 0x53,0x00 -> ioctl_download=1, three single-cycle ioctl_wr pulses with (addr,data) = (0,AA),(1,BB),(2,CC), then ioctl_download=0 and ioctl_addr=3.
REQ-037 Abort: SS2 raised after 5 bits of a data byte -> no ioctl_wr; the next full byte is written at the unchanged address.
REQ-038 Clkref (macro defined): clkref_n held high for 10 cycles after a data byte -> no ioctl_wr until clkref_n falls, then exactly one pulse.
REQ-039 Mid-reset: reset pulsed during the third data byte -> outputs 0 and no write for that byte.
